// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide unit with prev/next pipeline handshake
// Optional MULDIV_EARLY_OUT_EN: zero/overflow special cases complete one clock after accept.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        prev_done,
    output logic        stall_prev,
    input  logic [2:0]  operation_in,
    input  logic [31:0] lhs_in,
    input  logic [31:0] rhs_in,
    input  logic [4:0]  write_register_in,
    output logic        done_next,
    input  logic        next_stall,
    output logic [31:0] result_out,
    output logic [4:0]  write_register_out,
    output logic        busy_out
);
    localparam int DATA_WIDTH = 32;
    localparam int TAG_WIDTH  = $clog2(32);
    localparam int ITERATIONS = DATA_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t                  state_q, state_d;
    logic [4:0]              count_q, count_d;
    logic [2*DATA_WIDTH:0]   acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]   lhs_q, lhs_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [2:0]              op_q, op_d;
    logic                    neg_q, neg_d;
    logic                    lneg_q, lneg_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;

    logic transfer_prev, transfer_next, accept;

    assign stall_prev         = !rst_n || (state_q == ST_BUSY) || ((state_q == ST_DONE) && next_stall);
    assign done_next          = (state_q == ST_DONE);
    assign busy_out           = (state_q != ST_IDLE);
    assign result_out         = result_q;
    assign write_register_out = tag_q;
    assign transfer_prev      = prev_done && !stall_prev;
    assign transfer_next      = done_next && !next_stall;

    logic                  in_div, in_a_signed, in_b_signed, in_a_neg, in_b_neg;
    logic [DATA_WIDTH-1:0] in_a_mag, in_b_mag;

    always_comb begin
        in_div      = operation_in[2];
        in_a_signed = (operation_in == 3'd1) || (operation_in == 3'd2) ||
                      (operation_in == 3'd4) || (operation_in == 3'd6);
        in_b_signed = (operation_in == 3'd1) || (operation_in == 3'd4) || (operation_in == 3'd6);
        in_a_neg    = in_a_signed && lhs_in[31];
        in_b_neg    = in_b_signed && rhs_in[31];
        in_a_mag    = in_a_neg ? -lhs_in : lhs_in;
        in_b_mag    = in_b_neg ? -rhs_in : rhs_in;
    end

    // Multiply: acc = {partial sum, multiplier}; divide: acc = {remainder, dividend/quotient}.
    logic [32:0] mul_sum;
    logic [33:0] div_diff;
    logic [64:0] mul_step, acc_step;

    always_comb begin
        mul_sum  = acc_q[64:32] + {1'b0, mcand_q};
        mul_step = acc_q[0] ? {1'b0, mul_sum, acc_q[31:1]} : {1'b0, acc_q[64:1]};
        div_diff = {1'b0, acc_q[63:31]} - {2'b00, mcand_q};
        if (op_q[2]) begin
            acc_step = div_diff[33] ? {acc_q[63:0], 1'b0} : {div_diff[32:0], acc_q[30:0], 1'b1};
        end else begin
            acc_step = mul_step;
        end
    end

    logic [63:0]           prod;
    logic [DATA_WIDTH-1:0] quot, rem, fin_result;
    logic                  div_zero, div_ovf;

    always_comb begin
        prod     = neg_q ? -acc_step[63:0] : acc_step[63:0];
        quot     = neg_q ? -acc_step[31:0] : acc_step[31:0];
        rem      = lneg_q ? -acc_step[63:32] : acc_step[63:32];
        div_zero = (mcand_q == 32'd0);
        div_ovf  = ((op_q == 3'd4) || (op_q == 3'd6)) && (lhs_q == 32'h8000_0000) &&
                   (mcand_q == 32'd1) && (neg_q ^ lneg_q);
        if (op_q[2]) begin
            if (div_zero) begin
                fin_result = op_q[1] ? lhs_q : 32'hFFFF_FFFF;
            end else if (div_ovf) begin
                fin_result = op_q[1] ? 32'd0 : 32'h8000_0000;
            end else begin
                fin_result = op_q[1] ? rem : quot;
            end
        end else begin
            fin_result = (op_q[1:0] == 2'd0) ? prod[31:0] : prod[63:32];
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic                  in_special;
    logic [DATA_WIDTH-1:0] in_special_result;

    always_comb begin
        in_special        = 1'b0;
        in_special_result = 32'd0;
        if (in_div && (rhs_in == 32'd0)) begin
            in_special        = 1'b1;
            in_special_result = operation_in[1] ? lhs_in : 32'hFFFF_FFFF;
        end else if (((operation_in == 3'd4) || (operation_in == 3'd6)) &&
                     (lhs_in == 32'h8000_0000) && (rhs_in == 32'hFFFF_FFFF)) begin
            in_special        = 1'b1;
            in_special_result = operation_in[1] ? 32'd0 : 32'h8000_0000;
        end else if (!in_div && ((lhs_in == 32'd0) || (rhs_in == 32'd0))) begin
            in_special        = 1'b1;
            in_special_result = 32'd0;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        lhs_d    = lhs_q;
        result_d = result_q;
        op_d     = op_q;
        neg_d    = neg_q;
        lneg_d   = lneg_q;
        tag_d    = tag_q;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE: accept = transfer_prev;
            ST_BUSY: begin
                acc_d   = acc_step;
                count_d = (count_q == 5'd0) ? 5'd0 : count_q - 5'd1;
                if (count_q == 5'd0) begin
                    state_d  = ST_DONE;
                    result_d = fin_result;
                end
            end
            ST_DONE: begin
                if (transfer_next) begin
                    state_d = ST_IDLE;
                    accept  = transfer_prev;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            op_d    = operation_in;
            lhs_d   = lhs_in;
            tag_d   = write_register_in;
            neg_d   = in_a_neg ^ in_b_neg;
            lneg_d  = in_a_neg;
            mcand_d = in_div ? in_b_mag : in_a_mag;
            acc_d   = {33'd0, (in_div ? in_a_mag : in_b_mag)};
            count_d = 5'(ITERATIONS - 1);
            state_d = ST_BUSY;
`ifdef MULDIV_EARLY_OUT_EN
            if (in_special) begin
                state_d  = ST_DONE;
                result_d = in_special_result;
                count_d  = 5'd0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= 5'd0;
            acc_q    <= '0;
            mcand_q  <= '0;
            lhs_q    <= '0;
            result_q <= '0;
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            lneg_q   <= 1'b0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            lhs_q    <= lhs_d;
            result_q <= result_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            lneg_q   <= lneg_d;
            tag_q    <= tag_d;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prev_done = 1'b0;
    logic        next_stall = 1'b0;
    logic [2:0]  operation_in = 3'd0;
    logic [31:0] lhs_in = 32'd0;
    logic [31:0] rhs_in = 32'd0;
    logic [4:0]  write_register_in = 5'd0;
    logic        stall_prev, done_next, busy_out;
    logic [31:0] result_out;
    logic [4:0]  write_register_out;

    int errors = 0;
    int checks = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int SLAT = 1;
`else
    localparam int SLAT = 33;
`endif

    muldiv_sequencer dut (
        .clk(clk), .rst_n(rst_n), .prev_done(prev_done), .stall_prev(stall_prev),
        .operation_in(operation_in), .lhs_in(lhs_in), .rhs_in(rhs_in),
        .write_register_in(write_register_in), .done_next(done_next), .next_stall(next_stall),
        .result_out(result_out), .write_register_out(write_register_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = (op[2] && b == 0) ||
                  ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
                  (!op[2] && (a == 0 || b == 0));
        return special ? SLAT : 33;
    endfunction

    // Issues one op from IDLE, scrambles inputs after accept, waits for done with next_stall
    // held high, samples, then releases the result.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] res, output logic [4:0] tg,
                          output int lat);
        @(negedge clk);
        chk("idle_stall_prev", stall_prev, 1'b0);
        prev_done = 1'b1; operation_in = op; lhs_in = a; rhs_in = b; write_register_in = tag;
        next_stall = 1'b1;
        @(posedge clk);
        @(negedge clk);
        prev_done = 1'b0;
        lhs_in = $urandom; rhs_in = $urandom;
        operation_in = 3'($urandom); write_register_in = 5'($urandom);
        lat = 1;
        while (!done_next && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = result_out;
        tg  = write_register_out;
        next_stall = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vt[15];
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    logic        seen;

    initial begin
        vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFEB, 33};
        vt[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 33};
        vt[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 33};
        vt[3]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd3,  32'hFFFF_FFFD, 33};
        vt[4]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFF, 33};
        vt[5]  = '{3'd5, 32'd7,          32'd0,         5'd5,  32'hFFFF_FFFF, SLAT};
        vt[6]  = '{3'd7, 32'd7,          32'd0,         5'd6,  32'd7,         SLAT};
        vt[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, SLAT};
        vt[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'd0,         SLAT};
        vt[9]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFF, 33};
        vt[10] = '{3'd0, 32'd0,          32'd12345,     5'd11, 32'd0,         SLAT};
        vt[11] = '{3'd4, 32'd7,          32'd0,         5'd12, 32'hFFFF_FFFF, SLAT};
        vt[12] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         5'd13, 32'hFFFF_FFF9, SLAT};
        vt[13] = '{3'd5, 32'd100,        32'd7,         5'd14, 32'd14,        33};
        vt[14] = '{3'd7, 32'd100,        32'd7,         5'd31, 32'd2,         33};

        #2;
        chk("rst_stall_prev", stall_prev, 1'b1);
        chk("rst_done_next", done_next, 1'b0);
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_result", result_out, 32'd0);
        chk("rst_tag", write_register_out, 5'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, res, tg, lat);
            chk($sformatf("vec%0d_result", i), res, vt[i].exp);
            chk($sformatf("vec%0d_tag", i), tg, vt[i].tag);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            logic [4:0]  tag;
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            tag = 5'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'd0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = $urandom_range(1, 15);
                default: ;
            endcase
            run_op(op, a, b, tag, res, tg, lat);
            chk($sformatf("rand%0d_result", i), res, model(op, a, b));
            chk($sformatf("rand%0d_tag", i), tg, tag);
            chk($sformatf("rand%0d_latency", i), lat, model_lat(op, a, b));
        end

        // Result held in DONE under back-pressure, then a back-to-back accept.
        @(negedge clk);
        prev_done = 1'b1; operation_in = 3'd0; lhs_in = 32'd3; rhs_in = 32'd5;
        write_register_in = 5'd3; next_stall = 1'b1;
        @(posedge clk);
        @(negedge clk);
        prev_done = 1'b0;
        lat = 1;
        while (!done_next && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_reach_done", done_next, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_done_next", done_next, 1'b1);
            chk("hold_result", result_out, 32'd15);
            chk("hold_tag", write_register_out, 5'd3);
            chk("hold_stall_prev", stall_prev, 1'b1);
        end
        prev_done = 1'b1; operation_in = 3'd5; lhs_in = 32'd100; rhs_in = 32'd7;
        write_register_in = 5'd17; next_stall = 1'b0;
        #1;
        chk("b2b_stall_prev_low", stall_prev, 1'b0);
        @(posedge clk);
        @(negedge clk);
        prev_done = 1'b0; next_stall = 1'b1;
        chk("b2b_busy", busy_out, 1'b1);
        chk("b2b_not_done", done_next, 1'b0);
        lat = 1;
        while (!done_next && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_latency", lat, 33);
        chk("b2b_result", result_out, 32'd14);
        chk("b2b_tag", write_register_out, 5'd17);
        next_stall = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of an operation.
        prev_done = 1'b1; operation_in = 3'd1; lhs_in = $urandom; rhs_in = $urandom;
        write_register_in = 5'd22;
        @(posedge clk);
        @(negedge clk);
        prev_done = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy_out, 1'b0);
        chk("midrst_done_next", done_next, 1'b0);
        chk("midrst_result", result_out, 32'd0);
        chk("midrst_tag", write_register_out, 5'd0);
        chk("midrst_stall_prev", stall_prev, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_next || busy_out) seen = 1'b1;
        end
        chk("midrst_no_done_pulse", seen, 1'b0);
        run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd21, res, tg, lat);
        chk("postrst_result", res, model(3'd4, 32'hFFFF_FF9C, 32'd7));
        chk("postrst_tag", tg, 5'd21);
        chk("postrst_latency", lat, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
